// File: rtl/attn_pkg.sv
// Shared definitions for the attention-score pipeline.
//   DATA_WIDTH : default score width (signed fixed point)
//   Q_MIN/Q_MAX: saturation limits for 16-bit scores
//   state_e    : normaliser FSM states
//   ptr_width  : buffer pointer width for a given row length
package attn_pkg;

    localparam int unsigned DATA_WIDTH = 16;

    localparam logic [15:0] Q_MIN = 16'h8000;
    localparam logic [15:0] Q_MAX = 16'h7FFF;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/attn_score_normalizer_if.sv
// Score stream interface between the dot-product stage, the normaliser and
// the softmax exponent stage.
//   in_valid/in_data/in_ready     : upstream scores into the normaliser
//   out_valid/out_data/out_last/out_ready : normalised scores downstream
// Modports: slave = normaliser view, master = producer/consumer (bench) view.
interface attn_score_normalizer_if import attn_pkg::*; #(
    parameter int unsigned DATA_WIDTH = attn_pkg::DATA_WIDTH
) ();

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );

endinterface

// File: rtl/attn_sat_sub.sv
// Saturating signed subtraction o_diff = sat(i_a - i_b).
//   i_a, i_b : signed DATA_WIDTH operands
//   o_diff   : signed DATA_WIDTH result clamped to the representable range
module attn_sat_sub import attn_pkg::*; #(
    parameter int unsigned DATA_WIDTH = attn_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_diff
);

    localparam logic [DATA_WIDTH-1:0] SatMin = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] SatMax = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic [DATA_WIDTH:0] w_wide;

    // One guard bit: the difference of two N-bit values always fits in N+1.
    assign w_wide = {i_a[DATA_WIDTH-1], i_a} - {i_b[DATA_WIDTH-1], i_b};

    always_comb begin
        o_diff = w_wide[DATA_WIDTH-1:0];
        // Guard bit disagreeing with the N-bit sign means overflow.
        if (w_wide[DATA_WIDTH] != w_wide[DATA_WIDTH-1]) begin
            o_diff = w_wide[DATA_WIDTH] ? SatMin : SatMax;
        end
    end

endmodule

// File: rtl/attn_score_normalizer.sv
// Row-wise attention-score normaliser. Buffers one row of SEQ_LEN scores,
// each scaled by 2^-SHIFT, tracks the row maximum, then streams out
// sat(score - max) so every output is <= 0.
//   clk, reset : clock and asynchronous active-low reset
//   bus        : score stream (slave modport), in_* upstream, out_* downstream
//   row_max    : scaled maximum of the current row, stable during drain
//   busy       : a row is partially collected or draining
module attn_score_normalizer import attn_pkg::*; #(
    parameter int unsigned DATA_WIDTH = attn_pkg::DATA_WIDTH,
    parameter int unsigned SEQ_LEN    = 64,
    parameter int unsigned SHIFT      = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    attn_score_normalizer_if.slave  bus,
    output logic [DATA_WIDTH-1:0]   row_max,
    output logic                    busy
);

    localparam int unsigned           PtrW    = ptr_width(SEQ_LEN);
    localparam logic [PtrW-1:0]       LastIdx = PtrW'(SEQ_LEN - 1);
    localparam logic [DATA_WIDTH-1:0] MinVal  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_e                       r_state;
    logic [PtrW-1:0]              r_wr_ptr;
    logic [PtrW-1:0]              r_rd_ptr;
    logic signed [DATA_WIDTH-1:0] r_max;
    logic                         r_in_ready;
    logic                         r_out_valid;
    logic [DATA_WIDTH-1:0]        r_buf [SEQ_LEN];

    logic signed [DATA_WIDTH-1:0] w_scaled;
    logic [DATA_WIDTH-1:0]        w_rd_data;
    logic [DATA_WIDTH-1:0]        w_diff;
    logic                         w_in_fire;
    logic                         w_out_fire;
    logic                         w_rd_last;

    assign w_scaled   = $signed(bus.in_data) >>> SHIFT;
    assign w_in_fire  = bus.in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & bus.out_ready;
    assign w_rd_last  = (r_rd_ptr == LastIdx);
    assign w_rd_data  = r_buf[r_rd_ptr];

    // in_ready/out_valid are registered copies of the state decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= FILL;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_max       <= MinVal;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_in_fire) begin
                        if (w_scaled > r_max) begin
                            r_max <= w_scaled;
                        end
                        if (r_wr_ptr == LastIdx) begin
                            r_wr_ptr    <= '0;
                            r_state     <= DRAIN;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + PtrW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_out_fire) begin
                        if (w_rd_last) begin
                            r_rd_ptr    <= '0;
                            r_max       <= MinVal;
                            r_state     <= FILL;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + PtrW'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= FILL;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Row storage carries no reset; entries are always written before use.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_buf[r_wr_ptr] <= w_scaled;
        end
    end

    attn_sat_sub #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sat_sub (
        .i_a    (w_rd_data),
        .i_b    (r_max),
        .o_diff (w_diff)
    );

    // Gate data with valid so the unreset buffer never leaks to the port.
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_valid ? w_diff : '0;
    assign bus.out_last  = r_out_valid & w_rd_last;
    assign row_max       = r_max;
    assign busy          = (r_wr_ptr != '0) | (r_state == DRAIN);

endmodule

// File: tb/tb_attn_score_normalizer.sv
module tb_attn_score_normalizer;
    import attn_pkg::*;

    localparam int N = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel = 1'b0;           // 0: SHIFT=3 instance, 1: SHIFT=0 instance
    logic in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic out_ready = 1'b1;

    always #5 clk = ~clk;

    attn_score_normalizer_if #(.DATA_WIDTH(16)) if0 ();
    attn_score_normalizer_if #(.DATA_WIDTH(16)) if1 ();
    logic [15:0] rm0, rm1;
    logic        busy0, busy1;

    assign if0.in_valid  = in_valid & ~sel;
    assign if1.in_valid  = in_valid & sel;
    assign if0.in_data   = in_data;
    assign if1.in_data   = in_data;
    assign if0.out_ready = out_ready;
    assign if1.out_ready = out_ready;

    attn_score_normalizer #(.DATA_WIDTH(16), .SEQ_LEN(N), .SHIFT(3)) dut (
        .clk     (clk),
        .reset   (rst_n),
        .bus     (if0),
        .row_max (rm0),
        .busy    (busy0)
    );

    attn_score_normalizer #(.DATA_WIDTH(16), .SEQ_LEN(N), .SHIFT(0)) dut_s0 (
        .clk     (clk),
        .reset   (rst_n),
        .bus     (if1),
        .row_max (rm1),
        .busy    (busy1)
    );

    logic        m_in_ready, m_out_valid, m_out_last, m_busy, m_in_valid;
    logic [15:0] m_out_data, m_row_max;
    assign m_in_valid  = in_valid;
    assign m_in_ready  = sel ? if1.in_ready  : if0.in_ready;
    assign m_out_valid = sel ? if1.out_valid : if0.out_valid;
    assign m_out_data  = sel ? if1.out_data  : if0.out_data;
    assign m_out_last  = sel ? if1.out_last  : if0.out_last;
    assign m_row_max   = sel ? rm1 : rm0;
    assign m_busy      = sel ? busy1 : busy0;

    int vectors = 0;
    int miscompares = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: scores of the row being collected, then the queue of
    // outputs the row must produce.
    int          row_vals[$];
    logic [15:0] exp_q[$];
    logic [15:0] exp_row_max = 16'h8000;

    function automatic int scale(input logic [15:0] d, input int sh);
        int v;
        v = int'($signed(d));
        return v >>> sh;
    endfunction

    function automatic logic [15:0] sat16(input int d);
        if (d < -32768) return 16'h8000;
        if (d > 32767)  return 16'h7FFF;
        return d[15:0];
    endfunction

    // Per-row captures, pinned by hand-computed literals in the stimulus.
    int          rows_done = 0;
    int          cap_hs = 0, cap_n0 = 0, cap_n8000 = 0;
    logic [15:0] cap_first, cap_last_data, cap_row_max;
    logic        cap_last_flag;
    logic        prev_stall = 1'b0, prev_last;
    logic [15:0] prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            row_vals.delete();
            exp_q.delete();
            exp_row_max = 16'h8000;
            prev_stall  = 1'b0;
        end else begin
            bit drain;
            int run_max;
            drain = (exp_q.size() != 0);
            run_max = -32768;
            foreach (row_vals[k]) if (row_vals[k] > run_max) run_max = row_vals[k];
            check("in_ready", m_in_ready, !drain);
            check("out_valid", m_out_valid, drain);
            check("busy", m_busy, drain || row_vals.size() != 0);
            check("row_max", m_row_max, drain ? exp_row_max : run_max[15:0]);
            if (drain) begin
                check("out_data", m_out_data, exp_q[0]);
                check("out_last", m_out_last, exp_q.size() == 1);
                if (prev_stall) begin
                    check("hold_data", m_out_data, prev_data);
                    check("hold_last", m_out_last, prev_last);
                end
                prev_stall = !out_ready;
                prev_data  = m_out_data;
                prev_last  = m_out_last;
                if (out_ready) begin
                    if (cap_hs == 0) begin
                        cap_first   = m_out_data;
                        cap_row_max = m_row_max;
                    end
                    cap_hs++;
                    if (m_out_data == 16'h0000) cap_n0++;
                    if (m_out_data == Q_MIN) cap_n8000++;
                    if (exp_q.size() == 1) begin
                        cap_last_data = m_out_data;
                        cap_last_flag = m_out_last;
                        rows_done++;
                    end
                    void'(exp_q.pop_front());
                end
            end else begin
                check("out_data_idle", m_out_data, 16'h0000);
                check("out_last_idle", m_out_last, 1'b0);
                prev_stall = 1'b0;
            end
            if (m_in_valid && !drain) begin
                row_vals.push_back(scale(in_data, sel ? 0 : 3));
                if (row_vals.size() == N) begin
                    int mx;
                    mx = -32768;
                    foreach (row_vals[k]) if (row_vals[k] > mx) mx = row_vals[k];
                    foreach (row_vals[k]) exp_q.push_back(sat16(row_vals[k] - mx));
                    exp_row_max = mx[15:0];
                    row_vals.delete();
                    cap_hs = 0; cap_n0 = 0; cap_n8000 = 0;
                end
            end
        end
    end

    logic [15:0] stim [N];

    task automatic push(input logic [15:0] v);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        while (!m_in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("push_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_row();
        for (int i = 0; i < N; i++) push(stim[i]);
        in_valid = 1'b0;
    endtask

    task automatic drain_row(input bit alt);
        int t, target;
        t = 0;
        target = rows_done + 1;
        while (rows_done < target && t < 1000) begin
            out_ready = alt ? ~out_ready : 1'b1;
            @(posedge clk);
            #1;
            t++;
        end
        if (rows_done < target) check("drain_timeout", 32'd1, 32'd0);
        out_ready = 1'b1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", m_out_valid, 1'b0);
        check("rst_busy", m_busy, 1'b0);
        check("rst_row_max", m_row_max, Q_MIN);
        check("rst_in_ready", m_in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", m_in_ready, 1'b1);
        check("reset_out_valid", m_out_valid, 1'b0);
        check("reset_out_data", m_out_data, 16'h0000);
        check("reset_out_last", m_out_last, 1'b0);
        check("reset_row_max", m_row_max, 16'h8000);
        check("reset_busy", m_busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp: scaled values 0..63, outputs i-63.
        for (int i = 0; i < N; i++) stim[i] = 16'(i * 8);
        send_row();
        drain_row(1'b0);
        check("ramp_first", cap_first, 16'hFFC1);
        check("ramp_last", cap_last_data, 16'h0000);
        check("ramp_last_flag", cap_last_flag, 1'b1);
        check("ramp_row_max", cap_row_max, 16'd63);
        check("ramp_count", cap_hs, 64);

        // All most-negative inputs.
        for (int i = 0; i < N; i++) stim[i] = 16'h8000;
        send_row();
        drain_row(1'b0);
        check("min_row_max", cap_row_max, 16'hF000);
        check("min_zeros", cap_n0, 64);

        // Backpressure with in_valid held high during drain.
        for (int i = 0; i < N; i++) stim[i] = 16'((i * 613) ^ 16'hA5A5);
        send_row();
        in_valid = 1'b1;
        in_data  = 16'h1234;
        out_ready = 1'b1;
        drain_row(1'b1);
        in_valid = 1'b0;
        check("bp_count", cap_hs, 64);

        // Reset after 20 accepts, then a clean row of 80.
        for (int i = 0; i < 20; i++) push(16'(i * 100));
        in_valid = 1'b0;
        pulse_reset();
        for (int i = 0; i < N; i++) stim[i] = 16'd80;
        send_row();
        drain_row(1'b0);
        check("r80_row_max", cap_row_max, 16'd10);
        check("r80_zeros", cap_n0, 64);

        // Reset while draining.
        for (int i = 0; i < N; i++) stim[i] = 16'(i * 3);
        send_row();
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pulse_reset();
        out_ready = 1'b1;

        // Back-to-back rows: row 2 offered continuously through row 1 drain.
        for (int i = 0; i < N; i++) stim[i] = 16'(i * 10);
        stim[7] = 16'd8000;
        send_row();
        in_valid = 1'b1;
        in_data  = 16'hFFB0;
        drain_row(1'b0);
        check("b2b_row1_max", cap_row_max, 16'd1000);
        for (int i = 0; i < N; i++) push(16'hFFB0);
        in_valid = 1'b0;
        drain_row(1'b0);
        check("b2b_row2_max", cap_row_max, 16'hFFF6);
        check("b2b_row2_zeros", cap_n0, 64);

        // SHIFT=0 saturation.
        sel = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) stim[i] = Q_MIN;
        stim[5] = Q_MAX;
        send_row();
        drain_row(1'b0);
        check("sat_row_max", cap_row_max, 16'h7FFF);
        check("sat_n8000", cap_n8000, 63);
        check("sat_n0", cap_n0, 1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/attn_score_normalizer.md
# attn_score_normalizer

Row-wise attention-score normaliser, directly downstream of the 64-lane Q·K dot-product stage. It collects one row of SEQ_LEN 16-bit fixed-point scores, one per accepted cycle. Each score is scaled by 2^-SHIFT, which approximates 1/sqrt(d). The block tracks the row maximum, then streams out `score - max` over a valid/ready handshake to the softmax exponent stage.

## Interface
- Reset: one clock; reset is asynchronous and active-low.
- Parameters:
  - DATA_WIDTH, 16 — score width, signed two's-complement fixed point.
  - SEQ_LEN, 64 — scores per row (≥2).
  - SHIFT, 3 — arithmetic right shift applied to each input (1/sqrt(64) ≈ 2^-3).
- Ports (clock and reset first):
  - clk  in  1  — rising-edge clock.
  - reset  in  1  — asynchronous, active-low reset.
  - in_valid  in  1  — in_data holds a dot-product result.
  - in_data  in  DATA_WIDTH  — signed score from the dot-product stage.
  - in_ready  out  1  — block accepts a score this cycle.
  - out_valid  out  1  — out_data holds a normalised score.
  - out_data  out  DATA_WIDTH  — saturated (scaled score − row max), always ≤ 0.
  - out_last  out  1  — marks the final score of a row; qualified by out_valid.
  - out_ready  in  1  — consumer accepts out_data.
  - row_max  out  DATA_WIDTH  — scaled maximum of the current row.
  - busy  out  1  — row in progress.

## Operation
- Two-state FSM: FILL and DRAIN; reset state is FILL.
- FILL:
  - in_ready=1. An input is accepted when in_valid&in_ready.
  - s = in_data >>> SHIFT (sign-extending) is written to buf[wr_ptr]; wr_ptr increments.
  - max_q <= (s > max_q, signed) ? s : max_q.
  - The accept with wr_ptr==SEQ_LEN-1 moves to DRAIN and clears wr_ptr.
- DRAIN:
  - in_ready=0; in_valid is ignored.
  - out_valid=1; out_data = sat(buf[rd_ptr] − max_q); out_last = (rd_ptr==SEQ_LEN-1).
  - A handshake is out_valid&out_ready and advances rd_ptr.
  - The handshake with out_last moves to FILL, clears rd_ptr and resets max_q to 0x8000.
- Arithmetic:
  - Subtraction is done in DATA_WIDTH+1 bits.
  - Results below −2^(DATA_WIDTH-1) saturate to 0x8000.
  - Results above 2^(DATA_WIDTH-1)−1 saturate to 0x7FFF; this is unreachable, but required.
- row_max = max_q; it is stable for the whole DRAIN.
- busy = (wr_ptr≠0) | (state==DRAIN).
- Buffer: SEQ_LEN×DATA_WIDTH register array, no reset.

## Timing
- Reset values (asynchronous): state FILL, wr_ptr=rd_ptr=0, max_q=0x8000.
  - Resulting outputs: in_ready=1, out_valid=0, out_data=0 (gated by out_valid), out_last=0, row_max=0x8000, busy=0.
- Reset mid-row (either state) discards the partial row; the next row starts clean after release.
- Latency: out_valid rises the cycle after the SEQ_LEN-th input is accepted. out_data/out_last are combinational from registers in that cycle.
- Throughput: SEQ_LEN fill cycles plus ≥SEQ_LEN drain cycles per row. No overlap between rows.
- FILL is re-entered the cycle after the last-output handshake, with in_ready=1 in that same cycle.
- Backpressure: while out_valid&~out_ready, out_data, out_last and rd_ptr hold.
- in_valid has no required hold behaviour; the upstream stage simply retries.

## Structure
- Shared package `attn_pkg`:
  - DATA_WIDTH default.
  - Q_MIN = 16'h8000 and Q_MAX = 16'h7FFF.
  - FSM state enum {FILL, DRAIN}.
  - Pointer width function clog2(SEQ_LEN).
- Sub-module `attn_sat_sub`: combinational a−b with saturation, parameterised by DATA_WIDTH. It is reused by the later softmax stages.

## Test plan
- Ramp: SEQ_LEN=64, SHIFT=3, in_data=i*8 for i=0..63, out_ready=1.
  - row_max=63; outputs i−63.
  - First output 0xFFC1, last output 0x0000 with out_last=1.
  - out_valid first high 1 cycle after the 64th accept.
- All inputs 0x8000:
  - scaled value 0xF000, row_max=0xF000.
  - 64 outputs of 0x0000.
- Backpressure: out_ready alternating 1/0, with in_valid held high throughout DRAIN.
  - Exactly 64 handshakes; values held while out_ready=0, with no drop and no duplicate.
  - in_ready=0 for the whole DRAIN.
- Reset after 20 accepts:
  - out_valid=0, busy=0, row_max=0x8000 immediately.
  - A following full row of constant 80 yields row_max=10 and 64 outputs of 0.
- Back-to-back rows:
  - Row 1 has max input 8000 (row_max=1000).
  - Row 2 is all −80 (row_max=−10); row 2 is accepted the cycle after row 1's out_last handshake.
  - Row 2 outputs are all 0, proving max_q was cleared.
- SHIFT=0 saturation: inputs 0x7FFF once and 0x8000 otherwise.
  - row_max=0x7FFF.
  - The 0x8000 entries output 0x8000 (saturated); the 0x7FFF entry outputs 0x0000.
